mc_control: RTL
===============

Name: mc_control

Overview:
- Multicycle main controller for the mini-cpu datapath; produces the 3-bit alu_ctrl code the ALU consumes, plus all datapath mux selects and write strobes.
- Moore FSM sequences fetch/decode/execute/memory/writeback for an RV64I subset: ld/lw, sd/sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal.
- Owns the memory valid/ready handshake and a memory-wait watchdog.

Parameters:
- max_wait, 15: cycles mem_valid may stay high without mem_ready before entering FAULT; 0 disables the watchdog.
- wait_bits, 4: watchdog counter width; must hold max_wait.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_valid  out  1  memory access request
- adr_src  out  1  0 = pc, 1 = registered result
- mem_write  out  1  store strobe, qualified by mem_valid
- ir_write  out  1  latch instruction and old_pc
- pc_write  out  1  load pc from result
- reg_write  out  1  register file write
- alu_src_a  out  2  00 pc, 01 old_pc, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- result_src  out  2  00 alu_out reg, 01 data reg, 10 ALU result direct
- alu_ctrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- fault  out  1  sticky fault indicator

Behaviour:
- Reset: while rstn is low, mem_valid, mem_write, ir_write, pc_write and reg_write are forced to 0 combinationally. On the first edge with rstn low: state <= FETCH, watchdog <= 0, fault <= 0. Reset asserted mid-access abandons the access.
- Defaults, for any output not listed under a state: 0; alu_ctrl defaults to 010.
- FETCH:
  - Outputs: mem_valid=1, adr_src=0, a=00, b=10, add, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise hold FETCH.
- DECODE: a=01, b=01, add (branch/jal target into alu_out). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 with funct3=000 -> BEQ
  - 1101111 -> JAL
  - anything else -> illegal handling (see Optional Feature)
- MEMADR: a=10, b=01, add. Go to MEMREAD for a load opcode, MEMWRITE for a store opcode.
- MEMREAD: mem_valid=1, adr_src=1, result_src=00. Go to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: mem_valid=1, mem_write=1, adr_src=1, result_src=00. Go to FETCH on mem_ready.
- EXECR: a=10, b=00. Go to ALUWB.
  - funct3=000: 110 if funct7b5=1, else 010.
  - 010 -> 111; 110 -> 001; 111 -> 000.
  - Other funct3 -> illegal.
- EXECI: a=10, b=01. Same funct3 map, but funct7b5 is ignored (000 is always add). Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BEQ: a=10, b=00, alu_ctrl=110, result_src=00, pc_write=zero. Go to FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1. Go to ALUWB.
- Latency with zero-wait memory (mem_ready held high):
  - R/I-type: 4 cycles
  - ld: 5 cycles
  - sd: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Watchdog:
  - Counts consecutive cycles with mem_valid=1 and mem_ready=0; clears on mem_ready or on leaving a memory state.
  - If the count reaches max_wait (max_wait>0), go to FAULT on the next edge.
  - mem_ready arriving on that same cycle takes priority: the access completes normally.
- FAULT: all strobes 0, fault=1. Exited only by reset.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE, or an unsupported funct3 in EXECR/EXECI, goes to FAULT.
- Undefined: the instruction is treated as a NOP. The state returns to FETCH with no reg_write, mem_write or pc_write; pc already holds pc+4 from FETCH. fault only ever sets via the watchdog.

Test Plan:
- add (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECR (alu_ctrl=010), ALUWB (reg_write=1) over 4 cycles; back in FETCH on cycle 5.
- sub (funct7b5 1) -> alu_ctrl=110 in EXECR. addi with funct7b5=1 -> alu_ctrl=010 in EXECI. slt/or/and -> 111/001/000.
- beq with zero=1 -> pc_write=1 in BEQ. Same with zero=0 -> pc_write=0. Each is 3 cycles total.
- ld with mem_ready low for 3 cycles in MEMREAD -> state held, mem_valid=1, adr_src=1; MEMWB follows the ready cycle with result_src=01, reg_write=1.
- max_wait=15, mem_ready held 0 in FETCH -> FAULT after 15 cycles, fault=1, all strobes 0; rstn low for one edge -> FETCH, fault=0.
- opcode 1110011: with ILLEGAL_TRAP_EN -> FAULT after DECODE. Without it -> FETCH after DECODE, and no reg_write/mem_write/pc_write outside FETCH.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle Moore-FSM main controller for the mini-cpu datapath, with memory handshake watchdog.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes / funct3 values trap to FAULT instead of retiring as a NOP.
module mc_control #(
  parameter int max_wait  = 15,
  parameter int wait_bits = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_ctrl,
  output logic       fault
);

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
  localparam logic [3:0] ST_FAULT    = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] ST_ILLEGAL = ST_FAULT;
`else
  localparam logic [3:0] ST_ILLEGAL = ST_FETCH;
`endif

  // Fault is taken when the stall that is ending now would be the max_wait-th one.
  localparam logic [wait_bits-1:0] wd_last_c = wait_bits'(max_wait - 1);
  localparam logic [wait_bits-1:0] wd_one_c  = wait_bits'(1);

  logic [3:0]           state_r;
  logic [3:0]           state_nxt_s;
  logic [wait_bits-1:0] wd_cnt_r;
  logic                 wd_hit_s;
  logic [2:0]           f3_alu_s;
  logic                 f3_legal_s;
  logic                 mem_valid_s, adr_src_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;
  logic [1:0]           alu_src_a_s, alu_src_b_s, result_src_s;
  logic [2:0]           alu_ctrl_s;

  assign wd_hit_s = (max_wait > 0) && mem_valid_s && !mem_ready && (wd_cnt_r == wd_last_c);

  // ALU operation and legality of funct3 for R/I-type; only R-type honours funct7b5
  always_comb begin
    f3_alu_s   = 3'b010;
    f3_legal_s = 1'b1;
    case (funct3)
      3'b000:  f3_alu_s = (funct7b5 && (state_r == ST_EXECR)) ? 3'b110 : 3'b010;
      3'b010:  f3_alu_s = 3'b111;
      3'b110:  f3_alu_s = 3'b001;
      3'b111:  f3_alu_s = 3'b000;
      default: f3_legal_s = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready)     state_nxt_s = ST_DECODE;
        else if (wd_hit_s) state_nxt_s = ST_FAULT;
        else               state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt_s = ST_MEMADR;
          OP_RTYPE:          state_nxt_s = ST_EXECR;
          OP_ITYPE:          state_nxt_s = ST_EXECI;
          OP_BRANCH:         state_nxt_s = (funct3 == 3'b000) ? ST_BEQ : ST_ILLEGAL;
          OP_JAL:            state_nxt_s = ST_JAL;
          default:           state_nxt_s = ST_ILLEGAL;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LOAD)       state_nxt_s = ST_MEMREAD;
        else if (opcode == OP_STORE) state_nxt_s = ST_MEMWRITE;
        else                         state_nxt_s = ST_FETCH;
      end
      ST_MEMREAD: begin
        if (mem_ready)     state_nxt_s = ST_MEMWB;
        else if (wd_hit_s) state_nxt_s = ST_FAULT;
        else               state_nxt_s = ST_MEMREAD;
      end
      ST_MEMWRITE: begin
        if (mem_ready)     state_nxt_s = ST_FETCH;
        else if (wd_hit_s) state_nxt_s = ST_FAULT;
        else               state_nxt_s = ST_MEMWRITE;
      end
      ST_MEMWB:          state_nxt_s = ST_FETCH;
      ST_EXECR, ST_EXECI: state_nxt_s = f3_legal_s ? ST_ALUWB : ST_ILLEGAL;
      ST_ALUWB:          state_nxt_s = ST_FETCH;
      ST_BEQ:            state_nxt_s = ST_FETCH;
      ST_JAL:            state_nxt_s = ST_ALUWB;
      ST_FAULT:          state_nxt_s = ST_FAULT;
      default:           state_nxt_s = ST_FAULT;
    endcase
  end

  // Moore outputs per state; FETCH strobes ir/pc writes on the completing handshake
  always_comb begin
    mem_valid_s  = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    alu_ctrl_s   = 3'b010;
    case (state_r)
      ST_FETCH: begin
        mem_valid_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      ST_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      ST_MEMREAD: begin
        mem_valid_s = 1'b1;
        adr_src_s   = 1'b1;
      end
      ST_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_valid_s = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
      end
      ST_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_ctrl_s  = f3_alu_s;
      end
      ST_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_ctrl_s  = f3_alu_s;
      end
      ST_ALUWB:  reg_write_s = 1'b1;
      ST_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_ctrl_s  = 3'b110;
        pc_write_s  = zero;
      end
      ST_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      default: mem_valid_s = 1'b0;
    endcase
  end

  // State register and memory-stall watchdog
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r  <= ST_FETCH;
      wd_cnt_r <= {wait_bits{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (mem_valid_s && !mem_ready) wd_cnt_r <= wd_cnt_r + wd_one_c;
      else                           wd_cnt_r <= {wait_bits{1'b0}};
    end
  end

  // Strobes are held off combinationally while reset is low
  assign mem_valid  = rstn & mem_valid_s;
  assign mem_write  = rstn & mem_write_s;
  assign ir_write   = rstn & ir_write_s;
  assign pc_write   = rstn & pc_write_s;
  assign reg_write  = rstn & reg_write_s;
  assign adr_src    = adr_src_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign result_src = result_src_s;
  assign alu_ctrl   = alu_ctrl_s;
  assign fault      = (state_r == ST_FAULT);

endmodule
